// File: rtl/rom_boot_loader.sv
// Copies the HPS ROM download stream into SDRAM through a small FIFO, one write per ce_ref slot.
// Optional ROM_BOOT_LOADER_CHECKSUM_EN adds a modulo-256 checksum output over issued writes.
module rom_boot_loader #(
    parameter int         NUM_PAGES  = 3,
    parameter logic [8:0] PAGE0_BASE = 9'h000,
    parameter logic [8:0] PAGE1_BASE = 9'h100,
    parameter logic [8:0] PAGE2_BASE = 9'h107,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        ce_ref,
    input  logic        dl_en,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        ram_we,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic        overrun,
    output logic [24:0] bytes_written
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [10:0]   NUM_PAGES_C = 11'(NUM_PAGES);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [32:0]   fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrIdx;
    logic [CW-1:0] count_q, count_d;
    logic          dlEnPrev_q;
    logic          drainPending_q, drainPending_d;
    logic          ramWe_q, ramWe_d;
    logic [22:0]   ramAddr_q, ramAddr_d;
    logic [7:0]    ramDin_q, ramDin_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dropped_q, dropped_d;
    logic          overrun_q, overrun_d;
    logic [24:0]   bytesWritten_q, bytesWritten_d;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]    checksum_q, checksum_d;
`endif

    logic          start, fall, full, empty, push, pop, doneCond;
    logic [32:0]   head;
    logic [10:0]   headPage;
    logic          headMapped;

    function automatic logic [8:0] pageBase(input logic [10:0] page);
        case (page)
            11'd0:   pageBase = PAGE0_BASE;
            11'd1:   pageBase = PAGE1_BASE;
            default: pageBase = PAGE2_BASE;
        endcase
    endfunction

    // FIFO entries are {byte address, data}; the page number sits in the top address bits.
    assign head       = fifoMem_q[rdPtr_q];
    assign headPage   = head[32:22];
    assign headMapped = (headPage < NUM_PAGES_C);

    always_comb begin
        start    = dl_en & ~dlEnPrev_q;
        fall     = ~dl_en & dlEnPrev_q;
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        pop      = ~start & (state_q == S_IDLE) & ce_ref & ~empty;
        push     = dl_wr & dl_en & (start | ~full | pop);
        doneCond = ~dl_en & empty & (state_q == S_IDLE) & drainPending_q;

        state_d        = state_q;
        wrPtr_d        = wrPtr_q;
        rdPtr_d        = rdPtr_q;
        wrIdx          = wrPtr_q;
        count_d        = count_q;
        drainPending_d = drainPending_q;
        ramWe_d        = ramWe_q;
        ramAddr_d      = ramAddr_q;
        ramDin_d       = ramDin_q;
        done_d         = doneCond;
        dropped_d      = dropped_q;
        overrun_d      = overrun_q;
        bytesWritten_d = bytesWritten_q;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        checksum_d     = checksum_q;
`endif

        // A download start flushes the queue but still takes a byte strobed in the same cycle.
        if (start) begin
            wrIdx   = '0;
            rdPtr_d = '0;
            wrPtr_d = push ? PW'(1) : '0;
            count_d = push ? CW'(1) : '0;
        end else begin
            if (push)
                wrPtr_d = wrPtr_q + PW'(1);
            if (pop)
                rdPtr_d = rdPtr_q + PW'(1);
            if (push && !pop)
                count_d = count_q + CW'(1);
            else if (pop && !push)
                count_d = count_q - CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (headMapped) begin
                        ramAddr_d = {pageBase(headPage), head[21:8]};
                        ramDin_d  = head[7:0];
                        ramWe_d   = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (ce_ref) begin
                    ramWe_d = 1'b0;
                    state_d = S_IDLE;
                    if (bytesWritten_q != '1)
                        bytesWritten_d = bytesWritten_q + 25'd1;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q + ramDin_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            dropped_d      = 1'b0;
            overrun_d      = 1'b0;
            bytesWritten_d = '0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            checksum_d     = '0;
`endif
        end else if (dl_wr && dl_en && full && !pop) begin
            overrun_d = 1'b1;
        end

        // A restart cancels any pending completion; the next falling edge re-arms it.
        if (start)
            drainPending_d = 1'b0;
        else if (doneCond)
            drainPending_d = 1'b0;
        else if (fall)
            drainPending_d = 1'b1;

        busy_d = dl_en | (count_d != '0) | ramWe_d;
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q        <= S_IDLE;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            count_q        <= '0;
            dlEnPrev_q     <= 1'b0;
            drainPending_q <= 1'b0;
            ramWe_q        <= 1'b0;
            ramAddr_q      <= '0;
            ramDin_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dropped_q      <= 1'b0;
            overrun_q      <= 1'b0;
            bytesWritten_q <= '0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            wrPtr_q        <= wrPtr_d;
            rdPtr_q        <= rdPtr_d;
            count_q        <= count_d;
            dlEnPrev_q     <= dl_en;
            drainPending_q <= drainPending_d;
            ramWe_q        <= ramWe_d;
            ramAddr_q      <= ramAddr_d;
            ramDin_q       <= ramDin_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            dropped_q      <= dropped_d;
            overrun_q      <= overrun_d;
            bytesWritten_q <= bytesWritten_d;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            fifoMem_q[wrIdx] <= {dl_addr, dl_data};
    end

    assign dl_wait       = full;
    assign ram_we        = ramWe_q;
    assign ram_addr      = ramAddr_q;
    assign ram_din       = ramDin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dropped       = dropped_q;
    assign overrun       = overrun_q;
    assign bytes_written = bytesWritten_q;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: writes, page mapping, drop/overrun, drain, restart, async reset.
module tb_rom_boot_loader;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        ce_ref;
    logic        dl_en;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        ram_we;
    logic [22:0] ram_addr;
    logic [7:0]  ram_din;
    logic        busy;
    logic        done;
    logic        dropped;
    logic        overrun;
    logic [24:0] bytes_written;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;

    rom_boot_loader dut (
        .clk_sys       (clk_sys),
        .RESET_n       (RESET_n),
        .ce_ref        (ce_ref),
        .dl_en         (dl_en),
        .dl_wr         (dl_wr),
        .dl_addr       (dl_addr),
        .dl_data       (dl_data),
        .dl_wait       (dl_wait),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .busy          (busy),
        .done          (done),
        .dropped       (dropped),
        .overrun       (overrun),
        .bytes_written (bytes_written)
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // done is counted on the falling edge so every pulse is seen exactly once.
    always @(negedge clk_sys) begin
        if (done)
            doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk_sys);
    endtask

    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
        dl_wr   = 1'b1;
        dl_addr = addr;
        dl_data = data;
        @(negedge clk_sys);
        dl_wr   = 1'b0;
    endtask

    task automatic pulseRef();
        ce_ref = 1'b1;
        @(negedge clk_sys);
        ce_ref = 1'b0;
    endtask

    initial begin
        RESET_n = 1'b0;
        ce_ref  = 1'b0;
        dl_en   = 1'b0;
        dl_wr   = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        tick(3);

        checkOutput("rst_ram_we",   32'(ram_we), 32'h0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("rst_ram_din",  32'(ram_din), 32'h0);
        checkOutput("rst_dl_wait",  32'(dl_wait), 32'h0);
        checkOutput("rst_busy",     32'(busy), 32'h0);
        checkOutput("rst_flags",    32'({done, dropped, overrun}), 32'h0);
        checkOutput("rst_bytes",    32'(bytes_written), 32'h0);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        checkOutput("rst_checksum", 32'(checksum), 32'h0);
`endif
        RESET_n = 1'b1;
        tick(2);

        // Basic write: start and first byte in the same cycle.
        dl_en = 1'b1;
        applyStimulus(25'h0000004, 8'h3C);
        checkOutput("basic_busy",    32'(busy), 32'h1);
        checkOutput("basic_wait",    32'(dl_wait), 32'h0);
        checkOutput("basic_we_pre",  32'(ram_we), 32'h0);
        pulseRef();
        checkOutput("basic_we",      32'(ram_we), 32'h1);
        checkOutput("basic_addr",    32'(ram_addr), 32'h000004);
        checkOutput("basic_din",     32'(ram_din), 32'h3C);
        tick(5);
        checkOutput("basic_we_hold", 32'(ram_we), 32'h1);
        pulseRef();
        checkOutput("basic_we_fall", 32'(ram_we), 32'h0);
        checkOutput("basic_bytes",   32'(bytes_written), 32'h1);

        // Page mapping through bases 0x100 and 0x107; two queued bytes fill the FIFO.
        applyStimulus(25'h0004001, 8'hA1);
        applyStimulus(25'h0008002, 8'hB2);
        checkOutput("map_wait_full", 32'(dl_wait), 32'h1);
        pulseRef();
        checkOutput("map1_addr",     32'(ram_addr), 32'h400001);
        checkOutput("map1_din",      32'(ram_din), 32'hA1);
        checkOutput("map_wait_free", 32'(dl_wait), 32'h0);
        pulseRef();
        pulseRef();
        checkOutput("map2_we",       32'(ram_we), 32'h1);
        checkOutput("map2_addr",     32'(ram_addr), 32'h41C002);
        checkOutput("map2_din",      32'(ram_din), 32'hB2);
        pulseRef();
        checkOutput("map_bytes",     32'(bytes_written), 32'h3);

        // Page 3 is outside the image and is dropped without a write.
        applyStimulus(25'h000C000, 8'h11);
        pulseRef();
        checkOutput("unmap_dropped", 32'(dropped), 32'h1);
        checkOutput("unmap_we",      32'(ram_we), 32'h0);
        checkOutput("unmap_bytes",   32'(bytes_written), 32'h3);

        applyStimulus(25'h0000010, 8'h55);
        checkOutput("ovr_wait1",     32'(dl_wait), 32'h0);
        applyStimulus(25'h0000011, 8'h66);
        checkOutput("ovr_wait2",     32'(dl_wait), 32'h1);
        checkOutput("ovr_flag_pre",  32'(overrun), 32'h0);
        applyStimulus(25'h0000012, 8'h77);
        checkOutput("ovr_flag",      32'(overrun), 32'h1);

        // Drain: dl_en drops with two bytes still queued.
        dl_en = 1'b0;
        tick(1);
        checkOutput("drain_busy",    32'(busy), 32'h1);
        pulseRef();
        checkOutput("drain1_addr",   32'(ram_addr), 32'h000010);
        checkOutput("drain1_din",    32'(ram_din), 32'h55);
        pulseRef();
        checkOutput("drain_no_done", 32'(doneCount), 32'h0);
        pulseRef();
        checkOutput("drain2_addr",   32'(ram_addr), 32'h000011);
        checkOutput("drain2_din",    32'(ram_din), 32'h66);
        pulseRef();
        checkOutput("drain_bytes",   32'(bytes_written), 32'h5);
        checkOutput("drain_busy_lo", 32'(busy), 32'h0);
        checkOutput("drain_done_0",  32'(done), 32'h0);
        tick(1);
        checkOutput("drain_done_1",  32'(done), 32'h1);
        tick(1);
        checkOutput("drain_done_2",  32'(done), 32'h0);
        pulseRef();
        pulseRef();
        tick(3);
        checkOutput("drain_done_cnt", 32'(doneCount), 32'h1);

        // Restart: new download clears flags; re-rise during WRITE flushes the queue.
        dl_en = 1'b1;
        applyStimulus(25'h0000020, 8'h99);
        checkOutput("rs_dropped",    32'(dropped), 32'h0);
        checkOutput("rs_overrun",    32'(overrun), 32'h0);
        checkOutput("rs_bytes",      32'(bytes_written), 32'h0);
        applyStimulus(25'h0000021, 8'hAA);
        pulseRef();
        checkOutput("rs_we",         32'(ram_we), 32'h1);
        dl_en = 1'b0;
        tick(1);
        dl_en = 1'b1;
        tick(1);
        checkOutput("rs_we_keep",    32'(ram_we), 32'h1);
        checkOutput("rs_addr_keep",  32'(ram_addr), 32'h000020);
        checkOutput("rs_din_keep",   32'(ram_din), 32'h99);
        pulseRef();
        checkOutput("rs_we_end",     32'(ram_we), 32'h0);
        pulseRef();
        pulseRef();
        checkOutput("rs_flushed",    32'(ram_we), 32'h0);
        checkOutput("rs_no_done",    32'(doneCount), 32'h1);

        // Asynchronous reset in the middle of a write.
        applyStimulus(25'h000C000, 8'h01);
        pulseRef();
        checkOutput("rm_dropped",    32'(dropped), 32'h1);
        applyStimulus(25'h0000030, 8'hCC);
        pulseRef();
        checkOutput("rm_we",         32'(ram_we), 32'h1);
        checkOutput("rm_addr",       32'(ram_addr), 32'h000030);
        dl_en   = 1'b0;
        RESET_n = 1'b0;
        #1;
        checkOutput("rm_we_async",   32'(ram_we), 32'h0);
        checkOutput("rm_addr_clr",   32'(ram_addr), 32'h0);
        checkOutput("rm_dropped_clr", 32'(dropped), 32'h0);
        checkOutput("rm_bytes_clr",  32'(bytes_written), 32'h0);
        checkOutput("rm_busy_clr",   32'(busy), 32'h0);
        tick(2);
        RESET_n = 1'b1;
        tick(2);

        // Three page-0 bytes: 0xF0 + 0x20 + 0x05 = 0x115, checksum keeps the low byte.
        dl_en = 1'b1;
        applyStimulus(25'h0000000, 8'hF0);
        pulseRef();
        pulseRef();
        applyStimulus(25'h0000001, 8'h20);
        pulseRef();
        pulseRef();
        applyStimulus(25'h0000002, 8'h05);
        pulseRef();
        checkOutput("ck_last_addr",  32'(ram_addr), 32'h000002);
        pulseRef();
        checkOutput("ck_bytes",      32'(bytes_written), 32'h3);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        checkOutput("ck_checksum",   32'(checksum), 32'h15);
`endif
        dl_en = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
